// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default MMIO map, status bits.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [15:0] UART_TX_ADDR        = 16'hf001;
  localparam logic [15:0] UART_RX_DATA_ADDR   = 16'hf002;
  localparam logic [15:0] UART_RX_STATUS_ADDR = 16'hf003;

  // Bit positions inside the receiver status register.
  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_FERR_BIT  = 1;
  localparam int STAT_OVR_BIT   = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small byte FIFO for received UART data; head is shown combinationally.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic          doPush;
  logic          doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign doPop   = pop_i && !empty_o;
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign doPush  = push_i && (!full_o || doPop);
  assign data_o  = mem_q[rdPtr_q];

  // Storage array, written at the tail pointer.
  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with a byte FIFO, read through the shared MMIO bus.
module uart_rx
  import uart_pkg::*;
#(
  parameter int          DELAY_FRAMES = 234,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] DATA_ADDR    = UART_RX_DATA_ADDR,
  parameter logic [15:0] STATUS_ADDR  = UART_RX_STATUS_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] mmio_addr,
  input  logic        mmio_req,
  output logic [7:0]  mmio_rdata,
  output logic        mmio_done,
  output logic        rx_valid
);

  localparam int CNT_W = $clog2(DELAY_FRAMES);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DELAY_FRAMES / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);

  logic             rxMeta_q, rxSync_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             frameErr_q, frameErr_d;
  logic             overrun_q, overrun_d;
  logic             done_q, done_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             pushReq, frameErrSet, overrunSet, statusClr, popReq;
  logic [7:0]       fifoHead;
  logic             fifoFull, fifoEmpty;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (pushReq),
    .data_i  (shift_q),
    .pop_i   (popReq),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Frame sequencing: find the start edge, sample each bit at its centre.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    pushReq     = 1'b0;
    frameErrSet = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rxSync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          if (rxSync_q) begin
            state_d = RX_IDLE;
          end else begin
            cnt_d    = '0;
            bitIdx_d = '0;
            state_d  = RX_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[bitIdx_q] = rxSync_q;
          cnt_d             = '0;
          if (bitIdx_q == 3'd7) state_d  = RX_STOP;
          else                  bitIdx_d = bitIdx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          state_d = RX_IDLE;
          cnt_d   = '0;
          if (rxSync_q) pushReq     = 1'b1;
          else          frameErrSet = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // MMIO decode: one request per completion, done cycle ignores the bus.
  always_comb begin
    done_d    = 1'b0;
    rdata_d   = 8'h00;
    popReq    = 1'b0;
    statusClr = 1'b0;
    if (mmio_req && !done_q) begin
      if (mmio_addr == DATA_ADDR) begin
        done_d = 1'b1;
        if (!fifoEmpty) begin
          rdata_d = fifoHead;
          popReq  = 1'b1;
        end
      end else if (mmio_addr == STATUS_ADDR) begin
        done_d                 = 1'b1;
        rdata_d[STAT_VALID_BIT] = !fifoEmpty;
        rdata_d[STAT_FERR_BIT]  = frameErr_q;
        rdata_d[STAT_OVR_BIT]   = overrun_q;
        statusClr              = 1'b1;
      end
    end
  end

  // Sticky error flags; a new error beats a clearing status read.
  always_comb begin
    overrunSet = pushReq && fifoFull && !popReq;
    frameErr_d = frameErrSet || (frameErr_q && !statusClr);
    overrun_d  = overrunSet  || (overrun_q  && !statusClr);
  end

  // All state registers, including the two-flop rx synchroniser.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxMeta_q   <= 1'b1;
      rxSync_q   <= 1'b1;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      rxMeta_q   <= rx;
      rxSync_q   <= rxMeta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
    end
  end

  assign mmio_done  = done_q;
  assign mmio_rdata = rdata_q;
  assign rx_valid   = !fifoEmpty;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. 8N1 framing, LSB first, at the same baud as the existing MMIO UART transmitter.
- Deserialises the `rx` pin into a small byte FIFO.
- Exposes data and status registers on the shared 16-bit MMIO bus with the same req/done handshake as the transmitter.
- Sits beside the transmitter in the top level; the CPU polls status and pops bytes.

Parameters:
- DELAY_FRAMES, 234: clock cycles per bit (27 MHz / 115200).
- FIFO_DEPTH, 4: receive FIFO entries; must be a power of 2, ≥2.
- DATA_ADDR, 16'hf002: MMIO read address for the data register (pop).
- STATUS_ADDR, 16'hf003: MMIO read address for the status register.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  serial input from pin, idle high, asynchronous to clock
- mmio_addr  in  16  MMIO address
- mmio_req  in  1  MMIO read request
- mmio_rdata  out  8  read data, valid while mmio_done=1
- mmio_done  out  1  one-cycle completion pulse
- rx_valid  out  1  FIFO non-empty (poll/interrupt hint)

Behaviour:
- Reset (async, active-high):
  - synchroniser flops = 1; state = IDLE; counters = 0.
  - FIFO empty; frame_err = 0, overrun = 0.
  - mmio_done = 0, mmio_rdata = 0, rx_valid = 0.
- Synchroniser: rx passes through 2 flops (rx_s). All sampling uses rx_s, adding 2 cycles of latency.
- FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP. Bit counter cnt counts 0..DELAY_FRAMES-1.
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: when cnt+1 == DELAY_FRAMES/2, sample rx_s.
    - If rx_s==1: glitch, return to IDLE; nothing recorded.
    - If rx_s==0: cnt=0, bit=0, go to DATA.
  - DATA: when cnt+1 == DELAY_FRAMES, shift[bit] = rx_s and cnt=0. After bit 7, go to STOP. Otherwise cnt++.
  - STOP: when cnt+1 == DELAY_FRAMES, sample rx_s, then go to IDLE. The FSM leaves at mid-stop-bit so it can resync on a back-to-back start.
    - If rx_s==1: push the byte.
    - If rx_s==0: set frame_err and discard the byte.
- Push:
  - Accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise set overrun and drop the new byte; older data is kept.
  - The byte is visible (rx_valid=1) the cycle after the stop sample.
- MMIO reads (mmio_req=1, evaluated while mmio_done==0):
  - mmio_addr==DATA_ADDR:
    - Next cycle: mmio_done=1.
    - mmio_rdata = FIFO head, and the head is popped.
    - If the FIFO is empty: rdata=8'h00, no pop, still done.
  - mmio_addr==STATUS_ADDR:
    - Next cycle: mmio_done=1.
    - rdata = {5'b0, overrun, frame_err, !empty}.
    - frame_err and overrun clear on this read.
  - Any other address: no response; mmio_done stays 0.
  - mmio_done is a single-cycle pulse. A req still high in the done cycle is ignored, so a held req yields one pop per two cycles at most. The requester drops req on done.
  - mmio_rdata returns to 0 when done is low.
- Simultaneous events:
  - Push and pop in the same cycle: both occur; count unchanged (the full case is covered by the push rule above).
  - Error set and status-read clear in the same cycle: set wins, so the flag stays 1.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame aborts the frame and empties the FIFO. After release, a line held low is treated as a new start bit.

Decomposition:
- uart_pkg holds:
  - rx state enum type (RX_IDLE..RX_STOP);
  - default address constants UART_TX_ADDR=16'hf001, UART_RX_DATA_ADDR=16'hf002, UART_RX_STATUS_ADDR=16'hf003;
  - status bit index constants.
- Sub-module uart_rx_fifo:
  - parameterised depth, 8-bit width;
  - push/pop/full/empty ports;
  - async reset.

Test Plan (DELAY_FRAMES=8, FIFO_DEPTH=4):
- Send 8'h5A, stop=1, then read DATA_ADDR → status bit0=1 before the read; rdata=8'h5A with a one-cycle done; rx_valid=0 afterwards.
- rx low pulse of 3 cycles (< DELAY_FRAMES/2) → FSM returns to IDLE; FIFO empty; status reads 8'h00.
- Send 8'hC3 with stop bit 0 → FIFO empty; status=8'h02; a second status read returns 8'h00.
- Send 5 bytes 8'h01..8'h05 with no reads → status=8'h05 (overrun, non-empty); four DATA reads return 01,02,03,04; a fifth read returns 8'h00.
- Assert a DATA read in the exact cycle the 4th byte pushes while 3 are held → pop returns the head; count stays 3; no overrun.
- Assert reset during bit 4 of a frame, then send 8'hA5 → only A5 is received; a read to 16'hf001 gives no mmio_done.
